// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the alu_seq sequencer.
//   - alu_op_e   : legal ALU operation codes (10-15 are illegal)
//   - state_e    : sequencer FSM states
//   - cmd_t      : latched command payload
//   - helpers    : op_is_legal / op_is_shift decode
package alu_seq_pkg;

    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] rd;
        logic                 use_c;
        logic                 flag;
    } cmd_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_W'(OP_SHR);
    endfunction

    function automatic logic op_is_shift(input logic [OP_W-1:0] op);
        return (op == OP_W'(OP_SHL)) || (op == OP_W'(OP_SHR));
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: four n-bit registers R0-R3.
//   clk, rst            : clock, synchronous active-high reset (clears all)
//   ra_addr/ra_data     : combinational read port A
//   rb_addr/rb_data     : combinational read port B
//   wb_en/addr/data     : ALU writeback port
//   ld_en/addr/data     : direct load port (writeback takes priority)
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] ra_addr,
    output logic [n-1:0]         ra_data,
    input  logic [REG_IDX_W-1:0] rb_addr,
    output logic [n-1:0]         rb_data,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [n-1:0]         wb_data,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [n-1:0]         ld_data
);

    logic [n-1:0] regs_q [NUM_REGS];

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

    // Single write per cycle; writeback wins over a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end else if (ld_en) begin
            regs_q[ld_addr] <= ld_data;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer around an external ALU (IDLE -> EXEC -> RESP).
//   clk, rst                    : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*  : command handshake (accepted only in IDLE)
//   ld_en/ld_addr/ld_data       : direct register load (honoured only in IDLE)
//   alu_a/alu_b/alu_flag_in/alu_ctrl : drive the external ALU during EXEC, else 0
//   alu_result/alu_flags        : ALU return (flags bit0 C, bit1 Z)
//   rsp_valid/rsp_ready, rsp_*  : response handshake, held until accepted
//   op_count                    : completed responses, saturating; only counts
//                                 when ALU_SEQ_OPCOUNT_EN is defined, else 0
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_ra,
    input  logic [REG_IDX_W-1:0] cmd_rb,
    input  logic [REG_IDX_W-1:0] cmd_rd,
    input  logic                 cmd_use_c,
    input  logic                 cmd_flag,
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [n-1:0]         ld_data,
    output logic [n-1:0]         alu_a,
    output logic [n-1:0]         alu_b,
    output logic                 alu_flag_in,
    output logic [OP_W-1:0]      alu_ctrl,
    input  logic [n-1:0]         alu_result,
    input  logic [1:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [n-1:0]         rsp_result,
    output logic                 rsp_c,
    output logic                 rsp_z,
    output logic                 rsp_err,
    output logic [CNT_W-1:0]     op_count
);

    state_e       state_q, state_d;
    cmd_t         cmd_q, cmd_in;
    logic         c_q, z_q;
    logic [n-1:0] rsp_result_q;
    logic         rsp_err_q;
    logic [n-1:0] rd_a_data, rd_b_data;
    logic         op_legal, op_shift;
    logic         wb_en, rf_ld_en;

    assign cmd_in = '{op: cmd_op, ra: cmd_ra, rb: cmd_rb, rd: cmd_rd,
                      use_c: cmd_use_c, flag: cmd_flag};

    assign op_legal = op_is_legal(cmd_q.op);
    assign op_shift = op_is_shift(cmd_q.op);
    assign wb_en    = (state_q == ST_EXEC) && op_legal;
    assign rf_ld_en = (state_q == ST_IDLE) && ld_en;

    alu_seq_regfile #(.n(n)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (cmd_q.ra),
        .ra_data (rd_a_data),
        .rb_addr (cmd_q.rb),
        .rb_data (rd_b_data),
        .wb_en   (wb_en),
        .wb_addr (cmd_q.rd),
        .wb_data (alu_result),
        .ld_en   (rf_ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_flag_in = 1'b0;
        alu_ctrl    = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_a       = rd_a_data;
                alu_b       = rd_b_data;
                alu_ctrl    = cmd_q.op;
                alu_flag_in = cmd_q.use_c ? c_q : cmd_q.flag;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, flags and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && cmd_valid) begin
                cmd_q <= cmd_in;
            end
            if (state_q == ST_EXEC) begin
                if (op_legal) begin
                    rsp_result_q <= alu_result;
                    rsp_err_q    <= 1'b0;
                    z_q          <= alu_flags[1];
                    if (op_shift) c_q <= alu_flags[0];
                end else begin
                    rsp_result_q <= '0;
                    rsp_err_q    <= 1'b1;
                end
            end
        end
    end

    // C and Z only move at the EXEC edge, so they are stable through RESP;
    // an illegal op reports Z=1 without touching the stored Z.
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_c      = c_q;
    assign rsp_z      = z_q | rsp_err_q;

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [CNT_W-1:0] op_count_q;

    // Saturating count of response handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (rsp_valid && rsp_ready && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter n, default 4, datapath width in bits.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-005 SHALL have ports cmd_op in 4 (operation code), cmd_ra/cmd_rb/cmd_rd in 2 each (register indices), cmd_use_c in 1 (stored C as flag-in), cmd_flag in 1 (explicit flag-in).
REQ-006 SHALL have ports ld_en in 1, ld_addr in 2, ld_data in n: direct register load.
REQ-007 SHALL have ports alu_a out n, alu_b out n, alu_flag_in out 1, alu_ctrl out 4: drive the external ALU.
REQ-008 SHALL have ports alu_result in n, alu_flags in 2 (bit0 C, bit1 Z): ALU return.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out n, rsp_c out 1, rsp_z out 1, rsp_err out 1: response handshake.
REQ-010 SHALL have port op_count out 8: completed-command count (see Configuration).

Function
REQ-011 SHALL hold four n-bit registers R0-R3 and flag registers C, Z.
REQ-012 SHALL implement FSM IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-013 IDLE: cmd_valid&&cmd_ready at edge -> latch op, ra, rb, rd, flag-in source; go EXEC.
REQ-014 EXEC (exactly one cycle): alu_a=R[ra], alu_b=R[rb], alu_ctrl=op, alu_flag_in = use_c ? C : flag; outside EXEC all four ALU outputs = 0.
REQ-015 EXEC edge: capture alu_result/alu_flags into rsp regs, write R[rd], Z<=alu_flags[1], go RESP.
REQ-016 C SHALL update from alu_flags[0] only for ops 8, 9 (shifts); otherwise C unchanged; rsp_c = C after update.
REQ-017 Latency: rsp_valid asserted 2 cycles after accepting edge; minimum 3 cycles per command.
REQ-018 RESP: rsp_valid=1, rsp_* stable until rsp_ready sampled high, then IDLE; cmd_valid ignored in EXEC/RESP.
REQ-019 Op codes 10-15 SHALL be illegal: no R[rd] write, C/Z unchanged, rsp_result=0, rsp_z=1, rsp_err=1; legal ops rsp_err=0.
REQ-020 ld_en SHALL write R[ld_addr]<=ld_data only in IDLE; ignored in EXEC/RESP.
REQ-021 ld_en and command accept on same edge: load occurs; EXEC reads loaded value.
REQ-022 rd equal to ra or rb: operands read before write (write at EXEC edge).

Reset
REQ-023 rst SHALL, at any state including mid-EXEC, force IDLE with R0-R3=0, C=Z=0, rsp regs=0, rsp_valid=0, op_count=0, cmd_ready=1 next cycle.
REQ-024 Command in flight at reset SHALL be dropped with no register write.

Configuration
REQ-025 Macro ALU_SEQ_OPCOUNT_EN defined: op_count increments on each rsp handshake (rsp_valid&&rsp_ready), saturating at 255, illegal ops included.
REQ-026 Macro ALU_SEQ_OPCOUNT_EN undefined: no counter logic, op_count tied to 0.

Structure
REQ-027 Package alu_seq_pkg SHALL hold operation enum (0 and,1 or,2 add,3 inc,4 dec,5 not,6 sub,7 xor,8 shl,9 shr), FSM state typedef, register-index width constant.
REQ-028 Sub-module alu_seq_regfile SHALL implement R0-R3: two combinational read ports, one write port with internal load/writeback priority (writeback wins, unreachable by REQ-020).
REQ-029 ALU SHALL remain external, connected through alu_* ports.

Verification (n=4)
REQ-030 rst 2 cycles -> cmd_ready=1, rsp_valid=0, R0-R3=0, C=Z=0, op_count=0.
REQ-031 Load R0=5, R1=3; cmd op2 ra0 rb1 rd2 flag0 -> EXEC alu_a=5, alu_b=3, alu_ctrl=2; rsp_result=8, rsp_z=0, R2=8, rsp_valid 2 cycles after accept.
REQ-032 R0=4'b1001, R1=1, op8 flag0 -> rsp_result=4'b0010, rsp_c=1; next cmd op2 use_c=1 -> alu_flag_in=1.
REQ-033 R0=3, R1=3, op6 -> rsp_result=0, rsp_z=1, C unchanged.
REQ-034 rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, pulsing cmd_valid/ld_en changes nothing.
REQ-035 op12 -> rsp_err=1, rsp_result=0, R[rd] unchanged; separately rst during EXEC -> no write, IDLE next cycle.
